// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester ports and memory bus of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_lock;
  logic              req0_ready;
  logic              req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0_valid, req0_we, req0_addr,
    input  req0_wdata, req0_lock,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_addr,
    input  req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output req0_valid, req0_we, req0_addr,
    output req0_wdata, req0_lock,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_addr,
    output req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing the single-port memory
// between CPU (port 0) and debug/loader (port 1), one access at a time.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state;
  state_t            state_nx;
  logic              prio;
  logic              win;
  logic              we_q;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              any;
  logic              gnt1;
  logic              cap;

  assign any  = bus.req0_valid | bus.req1_valid;
  assign gnt1 = bus.req1_valid
              & (~bus.req0_valid | prio);
  // Read data is valid in the cycle that leads into RESP
  assign cap  = state_nx == RESP;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (any) state_nx = ISSUE;
      ISSUE: state_nx = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:  if (cnt <= 4'd1) state_nx = RESP;
      RESP:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.req0_rvalid = 1'b0;
    bus.req1_rvalid = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    unique case (state)
      IDLE: begin
        bus.req0_ready = reset & bus.req0_valid & ~gnt1;
        bus.req1_ready = reset & gnt1;
      end
      ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
      end
      WAIT: ;
      RESP: begin
        bus.req0_rvalid = ~win;
        bus.req1_rvalid = win;
      end
    endcase
  end

  assign bus.busy       = state != IDLE;
  assign bus.req0_rdata = rdata0;
  assign bus.req1_rdata = rdata1;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prio    <= 1'b0;
      win     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      if (state == IDLE && any) begin
        win     <= gnt1;
        we_q    <= gnt1 ? bus.req1_we : bus.req0_we;
        addr_q  <= gnt1 ? bus.req1_addr : bus.req0_addr;
        wdata_q <= gnt1 ? bus.req1_wdata
                        : bus.req0_wdata;
        // a locked CPU grant keeps priority on port 0
        prio    <= ~gnt1 & ~bus.req0_lock;
      end
      if (state == ISSUE)     cnt <= LAT_M1;
      else if (state == WAIT) cnt <= cnt - 4'd1;
      if (cap && !win) rdata0 <= bus.mem_rdata;
      if (cap && win)  rdata1 <= bus.mem_rdata;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares the machine's single-port memory bus between the CPU core (port 0) and the debug/loader port (port 1). It sits between both requesters and the memory inside `machine`. It accepts one transaction at a time, sequences the memory access over a fixed read latency, and returns read data (or a write acknowledge) to the requester that was granted. Round-robin fairness is used, with an optional CPU lock for atomic read-modify-write.

## Interface
- ADDR_W, 16, address width
- DATA_W, 8, data width
- MEM_LAT, 1, memory read latency in cycles from the `mem_en` cycle to valid `mem_rdata`; legal values 1..15

- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_W  access address
- req0_wdata / req1_wdata  in  DATA_W  write data
- req0_lock  in  1  CPU holds priority for its next request (read-modify-write)
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_rvalid / req1_rvalid  out  1  one-cycle completion pulse; indicates read data or a write ack
- req0_rdata / req1_rdata  out  DATA_W  read data, valid while the matching rvalid is high
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any valid is high, select a winner:
    - If only one valid is high, that requester wins.
    - If both are high, the winner is the port named by the priority pointer `prio`.
  - `reqN_ready` for the winner is combinationally high in this cycle.
  - Latch winner id, we, addr and wdata; go to ISSUE.
  - If no valid is high, stay in IDLE.
- ISSUE: `mem_en`=1 for exactly one cycle, with `mem_we`, `mem_addr` and `mem_wdata` driven from the latched values. Go to WAIT, or to RESP if MEM_LAT=1.
- WAIT: a down-counter runs MEM_LAT-1 cycles. On its last cycle `mem_rdata` is valid.
- Data capture: `mem_rdata` is captured into the winner's rdata register on the edge where MEM_LAT cycles have elapsed since ISSUE.
- RESP: `reqN_rvalid`=1 for the winner for one cycle. Writes also pulse rvalid, and rdata is then don't-care. Next state is IDLE.
- Priority pointer:
  - After a grant to port 1, `prio` becomes 0.
  - After a grant to port 0, `prio` becomes 1, unless `req0_lock` was high at the grant, in which case `prio` stays 0.
- Requester rule: valid and fields must be held stable until ready. Valid outside IDLE is ignored, not queued.
- `mem_*` outputs are 0 outside ISSUE. The other port's ready and rvalid are always 0 during a transaction.

## Timing
- Reset (reset=0, async): state=IDLE, prio=0, counter=0, all outputs 0 (ready, rvalid, rdata, mem_*, busy). Any in-flight transaction is dropped and no rvalid is issued. Release is synchronous to the next clk edge.
- Latency: ready in cycle T, mem_en in T+1, rvalid in T+2+MEM_LAT-1 (MEM_LAT=1 gives rvalid at T+2).
- Throughput: the next ready is possible at T+2+MEM_LAT. Back-to-back transactions from one port are spaced MEM_LAT+2 cycles apart.
- busy is high from T+1 through the RESP cycle inclusive.
- Simultaneous valid in IDLE: arbitrated by `prio`. Under continuous contention and no lock, grants alternate 0,1,0,1.
- A lock held continuously starves port 1. This is accepted by design; the CPU must drop the lock after its RMW.
- A requester dropping valid before ready causes no grant and no side effects.

## Test plan
- Reset: hold reset=0 with both valids high -> all outputs 0. After release with only req1 valid -> req1_ready in the first IDLE cycle.
- Single read, MEM_LAT=1: req0 read of addr 0x0010, memory returns 0xA5 -> ready at T, mem_en with addr 0x0010 at T+1, req0_rvalid with rdata 0xA5 at T+2, busy low at T+3.
- Write: req1 write 0x3C to 0x1234 -> mem_en=1, mem_we=1, mem_addr=0x1234, mem_wdata=0x3C for one cycle; req1_rvalid pulses once; req0 outputs stay 0.
- Contention: both valid continuously for 4 transactions, no lock -> grant order 0,1,0,1; rvalid on the matching port each time; spacing MEM_LAT+2 cycles.
- Lock: both valid, req0_lock=1 for 2 grants and then 0 -> order 0,0,0,1.
- Reset mid-op with MEM_LAT=3: assert reset during WAIT -> no rvalid, mem_en=0 and busy=0 immediately. After release, a fresh req1 read completes with correct data.
